// File: rtl/rle_coef_expand.sv
// Run/size token expander for the JPEG AC path: turns RS tokens plus amplitude
// bits into a stream of exactly BLOCK_LEN signed coefficients per block.
module rle_coef_expand #(
    parameter int BLOCK_LEN = 64,
    parameter int AMP_W     = 12,
    parameter int COEF_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rs_d,
    input  logic [AMP_W-1:0]  amp_d,
    input  logic              rs_valid,
    output logic              rs_ready,
    output logic [COEF_W-1:0] coef_d,
    output logic [5:0]        coef_idx,
    output logic              coef_last,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              err
);

    localparam logic [5:0] LAST_IDX = 6'(BLOCK_LEN - 1);
    localparam int         MAX_SIZE = AMP_W - 1;

    typedef enum logic [1:0] {ACCEPT, ZEROS, VALUE, FILL} state_t;

    state_t              state_reg;
    logic [5:0]          idx_reg;
    logic [3:0]          zcnt_reg;
    logic                has_value_reg;
    logic [COEF_W-1:0]   value_reg;
    logic [COEF_W-1:0]   coef_d_reg;
    logic [5:0]          coef_idx_reg;
    logic                coef_last_reg;
    logic                coef_valid_reg;
    logic                err_reg;

    logic [3:0]          tok_run;
    logic [3:0]          tok_size;
    logic                is_eob;
    logic                is_zrl;
    logic                bad_zero;
    logic                bad_size;
    logic [6:0]          span_end;
    logic                overflow;
    logic [COEF_W-1:0]   mask;
    logic [COEF_W-1:0]   mag;
    logic                sign_bit;
    logic [COEF_W-1:0]   decoded;
    logic                out_free;
    logic                at_last;
    logic [5:0]          idx_next;

    assign tok_run  = rs_d[7:4];
    assign tok_size = rs_d[3:0];
    assign is_zrl   = (tok_size == 4'd0) && (tok_run == 4'hF);
    assign is_eob   = (tok_size == 4'd0) && (tok_run != 4'hF);
    assign bad_zero = is_eob && (tok_run != 4'd0);
    assign bad_size = int'(tok_size) > MAX_SIZE;

    // Index of the last coefficient this token would place; past the block end
    // the token is truncated with zeros.
    assign span_end = {1'b0, idx_reg} + (is_zrl ? 7'd15 : {3'b000, tok_run});
    assign overflow = !is_eob && (span_end > {1'b0, LAST_IDX});

    // JPEG EXTEND: top amplitude bit set means positive, else v - (2^S - 1).
    always_comb begin
        mask     = (COEF_W'(1) << tok_size) - COEF_W'(1);
        mag      = COEF_W'(amp_d) & mask;
        sign_bit = |(mag & (mask ^ (mask >> 1)));
        decoded  = '0;
        if (tok_size != 4'd0 && !bad_size)
            decoded = sign_bit ? mag : (mag - mask);
    end

    assign out_free = !coef_valid_reg || coef_ready;
    assign rs_ready = (state_reg == ACCEPT) && out_free;
    assign at_last  = (idx_reg == LAST_IDX);
    assign idx_next = at_last ? 6'd0 : (idx_reg + 6'd1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= ACCEPT;
            idx_reg        <= '0;
            zcnt_reg       <= '0;
            has_value_reg  <= 1'b0;
            value_reg      <= '0;
            coef_d_reg     <= '0;
            coef_idx_reg   <= '0;
            coef_last_reg  <= 1'b0;
            coef_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else if (out_free) begin
            coef_valid_reg <= 1'b0;
            coef_last_reg  <= 1'b0;
            case (state_reg)
                ACCEPT: begin
                    if (rs_valid) begin
                        coef_valid_reg <= 1'b1;
                        coef_idx_reg   <= idx_reg;
                        coef_last_reg  <= at_last;
                        coef_d_reg     <= '0;
                        idx_reg        <= idx_next;
                        value_reg      <= decoded;
                        if (bad_size || bad_zero || overflow)
                            err_reg <= 1'b1;
                        if (is_eob || overflow) begin
                            state_reg <= at_last ? ACCEPT : FILL;
                        end else if (is_zrl) begin
                            zcnt_reg      <= 4'd15;
                            has_value_reg <= 1'b0;
                            state_reg     <= ZEROS;
                        end else if (tok_run == 4'd0) begin
                            coef_d_reg <= decoded;
                            state_reg  <= ACCEPT;
                        end else if (tok_run == 4'd1) begin
                            state_reg <= VALUE;
                        end else begin
                            zcnt_reg      <= tok_run - 4'd1;
                            has_value_reg <= 1'b1;
                            state_reg     <= ZEROS;
                        end
                    end
                end
                ZEROS: begin
                    coef_valid_reg <= 1'b1;
                    coef_idx_reg   <= idx_reg;
                    coef_last_reg  <= at_last;
                    coef_d_reg     <= '0;
                    idx_reg        <= idx_next;
                    zcnt_reg       <= zcnt_reg - 4'd1;
                    if (zcnt_reg == 4'd1)
                        state_reg <= has_value_reg ? VALUE : ACCEPT;
                end
                VALUE: begin
                    coef_valid_reg <= 1'b1;
                    coef_idx_reg   <= idx_reg;
                    coef_last_reg  <= at_last;
                    coef_d_reg     <= value_reg;
                    idx_reg        <= idx_next;
                    state_reg      <= ACCEPT;
                end
                FILL: begin
                    coef_valid_reg <= 1'b1;
                    coef_idx_reg   <= idx_reg;
                    coef_last_reg  <= at_last;
                    coef_d_reg     <= '0;
                    idx_reg        <= idx_next;
                    if (at_last)
                        state_reg <= ACCEPT;
                end
                default: state_reg <= ACCEPT;
            endcase
        end
    end

    assign coef_d     = coef_d_reg;
    assign coef_idx   = coef_idx_reg;
    assign coef_last  = coef_last_reg;
    assign coef_valid = coef_valid_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_rle_coef_expand.sv
// Directed bench for rle_coef_expand: token streams with hand-computed blocks,
// backpressure, overflow and mid-block reset.
module tb_rle_coef_expand;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rs_d = '0;
    logic [11:0] amp_d = '0;
    logic        rs_valid = 1'b0;
    logic        rs_ready;
    logic [15:0] coef_d;
    logic [5:0]  coef_idx;
    logic        coef_last;
    logic        coef_valid;
    logic        coef_ready = 1'b1;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mon_d    [0:1023];
    logic [5:0]  mon_idx  [0:1023];
    logic        mon_last [0:1023];
    int          mon_cnt = 0;
    logic [15:0] exp_d    [0:63];

    rle_coef_expand dut (
        .clock      (clock),
        .reset      (reset),
        .rs_d       (rs_d),
        .amp_d      (amp_d),
        .rs_valid   (rs_valid),
        .rs_ready   (rs_ready),
        .coef_d     (coef_d),
        .coef_idx   (coef_idx),
        .coef_last  (coef_last),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .err        (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset && coef_valid && coef_ready && mon_cnt < 1024) begin
            mon_d[mon_cnt]    = coef_d;
            mon_idx[mon_cnt]  = coef_idx;
            mon_last[mon_cnt] = coef_last;
            mon_cnt           = mon_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_d[i] = 16'h0000;
    endtask

    task automatic send_token(input logic [7:0] rs, input logic [11:0] amp);
        int n = 0;
        @(negedge clock);
        rs_d = rs; amp_d = amp; rs_valid = 1'b1;
        while (!rs_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!rs_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        @(negedge clock);
        rs_valid = 1'b0;
        $display("token rs=%02h amp=%03h accepted", rs, amp);
    endtask

    task automatic check_block(input string tag, input int base);
        int n = 0;
        while (mon_cnt < base + 64 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_complete"}, 32'(mon_cnt >= base + 64), 32'd1);
        if (mon_cnt >= base + 64) begin
            for (int i = 0; i < 64; i++) begin
                check({tag, "_idx"},  32'(mon_idx[base+i]), 32'(i));
                check({tag, "_d"},    32'(mon_d[base+i]),   32'(exp_d[i]));
                check({tag, "_last"}, 32'(mon_last[base+i]), 32'(i == 63));
            end
        end
        $display("block %s checked, err=%0b", tag, err);
    endtask

    int base;
    int n;
    logic [5:0]  hold_idx;
    logic [15:0] hold_d;

    initial begin
        // reset state
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(coef_valid), 32'd0);
        check("rst_last",  32'(coef_last),  32'd0);
        check("rst_d",     32'(coef_d),     32'd0);
        check("rst_idx",   32'(coef_idx),   32'd0);
        check("rst_err",   32'(err),        32'd0);
        reset = 1'b1;

        // +5 at idx0, EOB fill
        base = mon_cnt;
        send_token(8'h03, 12'h005);
        check("t1_first_valid", 32'(coef_valid), 32'd1);
        check("t1_first_d",     32'(coef_d),     32'h5);
        send_token(8'h00, 12'h000);
        clear_exp(); exp_d[0] = 16'h0005;
        check_block("t1", base);
        check("t1_err", 32'(err), 32'd0);

        // run 2 then -5, first coef one cycle after accept
        base = mon_cnt;
        send_token(8'h23, 12'h002);
        check("t2_lat_valid", 32'(coef_valid), 32'd1);
        check("t2_lat_idx",   32'(coef_idx),   32'd0);
        check("t2_lat_d",     32'(coef_d),     32'd0);
        send_token(8'h00, 12'h000);
        clear_exp(); exp_d[2] = 16'hFFFB;
        check_block("t2", base);

        // ZRL, then run1 size1 amp0 -> -1 at idx17
        base = mon_cnt;
        send_token(8'hF0, 12'h000);
        send_token(8'h11, 12'h000);
        send_token(8'h00, 12'h000);
        clear_exp(); exp_d[17] = 16'hFFFF;
        check_block("t3", base);

        // backpressure mid-ZEROS
        base = mon_cnt;
        send_token(8'hA1, 12'h001);
        repeat (2) @(negedge clock);
        coef_ready = 1'b0;
        hold_idx = coef_idx; hold_d = coef_d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t4_hold_valid", 32'(coef_valid), 32'd1);
            check("t4_hold_idx",   32'(coef_idx),   32'(hold_idx));
            check("t4_hold_d",     32'(coef_d),     32'(hold_d));
            check("t4_rs_ready",   32'(rs_ready),   32'd0);
        end
        coef_ready = 1'b1;
        send_token(8'h00, 12'h000);
        clear_exp(); exp_d[10] = 16'h0001;
        check_block("t4", base);
        check("t4_err", 32'(err), 32'd0);

        // overflow: 3 ZRL, +1 at 59, then 0xF1 at idx60
        base = mon_cnt;
        send_token(8'hF0, 12'h000);
        send_token(8'hF0, 12'h000);
        send_token(8'hF0, 12'h000);
        send_token(8'hB1, 12'h001);
        send_token(8'hF1, 12'h001);
        clear_exp(); exp_d[59] = 16'h0001;
        check_block("t5", base);
        check("t5_err", 32'(err), 32'd1);
        base = mon_cnt;
        send_token(8'h01, 12'h001);
        check("t5_next_idx", 32'(coef_idx), 32'd0);
        check("t5_next_d",   32'(coef_d),   32'd1);
        send_token(8'h00, 12'h000);
        clear_exp(); exp_d[0] = 16'h0001;
        check_block("t5b", base);
        check("t5_err_sticky", 32'(err), 32'd1);

        // reset during FILL around idx 30
        base = mon_cnt;
        send_token(8'h00, 12'h000);
        n = 0;
        while (mon_cnt < base + 30 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("t6_reached30", 32'(mon_cnt >= base + 30), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check("t6_valid", 32'(coef_valid), 32'd0);
        check("t6_err",   32'(err),        32'd0);
        reset = 1'b1;
        base = mon_cnt;
        send_token(8'h12, 12'h003);
        check("t6_first_idx", 32'(coef_idx), 32'd0);
        send_token(8'h00, 12'h000);
        clear_exp(); exp_d[1] = 16'h0003;
        check_block("t6", base);

        // S=11 negative extreme, then illegal S=12 decodes to 0 and flags err
        base = mon_cnt;
        send_token(8'h0B, 12'h000);
        check("t7_err_pre", 32'(err), 32'd0);
        send_token(8'h0C, 12'hFFF);
        send_token(8'h00, 12'h000);
        clear_exp(); exp_d[0] = 16'hF801;
        check_block("t7", base);
        check("t7_err", 32'(err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
